// File: rtl/ysyx_25040129_axi_sram_if.sv
// AXI4-subset bus between a master (MMU, CPU forwarder or bench) and the SRAM responder.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// a source keeps valid and its payload unchanged until that edge.
interface ysyx_25040129_axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, arsize, arlen, arburst, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, rlast,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, arsize, arlen, arburst, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, rlast,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25040129_axi_sram.sv
// Word-organised SRAM behind an AXI4 subset: one transaction at a time, strobed single-beat
// writes, FIXED/INCR/WRAP read bursts, programmable wait states, writes win over reads.
module ysyx_25040129_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 2,
    parameter int          WR_LATENCY  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_25040129_axi_sram_if.slave         axi,
    output logic [2:0]                      state_o
);
    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [15:0] RD_INIT = 16'(RD_LATENCY - 1);
    localparam logic [15:0] WR_INIT = 16'(WR_LATENCY - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_COLLECT = 3'd1;
    localparam logic [2:0] S_WR_WAIT    = 3'd2;
    localparam logic [2:0] S_WR_RESP    = 3'd3;
    localparam logic [2:0] S_RD_WAIT    = 3'd4;
    localparam logic [2:0] S_RD_DATA    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_en_q;
    logic [31:0] aw_addr_q;
    logic        aw_got_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        w_got_q;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic [7:0]  ar_len_q;
    logic [1:0]  ar_burst_q;
    logic [7:0]  beat_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;
    logic [1:0]  bresp_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        ar_hs, aw_hs, w_hs;
    logic        wr_commit, wr_ok;
    logic        rd_load0, rd_adv, ld_err;
    logic [31:0] ld_addr;
    logic [7:0]  ld_beat;

    function automatic logic in_range(input logic [31:0] a);
        return (a - ADDR_BASE) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    // WRAP keeps the upper bits of the aligned block and wraps the low bits inside it.
    function automatic logic [31:0] next_beat(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] inc, mask;
        inc  = 32'd1 << size[1:0];
        mask = ((32'(len) + 32'd1) << size[1:0]) - 32'd1;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + inc) & mask);
            default: return a + inc;
        endcase
    endfunction

    assign ar_hs = axi.arvalid & axi.arready;
    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;

    always_comb begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        if (ready_en_q) begin
            case (state_q)
                S_IDLE: begin
                    axi.awready = 1'b1;
                    axi.wready  = 1'b1;
                    axi.arready = !(axi.awvalid | axi.wvalid);
                end
                S_WR_COLLECT: begin
                    axi.awready = !aw_got_q;
                    axi.wready  = !w_got_q;
                end
                default: ;
            endcase
        end
    end

    assign axi.rvalid = (state_q == S_RD_DATA);
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign axi.rlast  = rlast_q & axi.rvalid;
    assign axi.bvalid = (state_q == S_WR_RESP);
    assign axi.bresp  = bresp_q;
    assign state_o    = state_q;

    assign wr_commit = (state_q == S_WR_WAIT) && (cnt_q == 16'd0);
    assign wr_ok     = in_range(aw_addr_q);
    assign rd_load0  = (state_q == S_RD_WAIT) && (cnt_q == 16'd0);
    assign rd_adv    = (state_q == S_RD_DATA) && axi.rready && !rlast_q;
    assign ld_addr   = rd_load0 ? ar_addr_q : next_beat(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
    assign ld_beat   = rd_load0 ? 8'd0 : beat_q + 8'd1;
    assign ld_err    = (ar_burst_q == 2'b11) || (ar_size_q > 3'd2) || !in_range(ld_addr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = S_WR_WAIT;
                    cnt_d   = WR_INIT;
                end else if (aw_hs || w_hs) begin
                    state_d = S_WR_COLLECT;
                end else if (ar_hs) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = RD_INIT;
                end
            end
            S_WR_COLLECT: begin
                if (aw_hs || w_hs) begin
                    state_d = S_WR_WAIT;
                    cnt_d   = WR_INIT;
                end
            end
            S_WR_WAIT: begin
                if (cnt_q == 16'd0) state_d = S_WR_RESP;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_WR_RESP: if (axi.bready) state_d = S_IDLE;
            S_RD_WAIT: begin
                if (cnt_q == 16'd0) state_d = S_RD_DATA;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_RD_DATA: if (axi.rready && rlast_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_got_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            w_got_q    <= 1'b0;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
            beat_q     <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            bresp_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                aw_addr_q <= axi.awaddr;
                aw_got_q  <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
                w_got_q  <= 1'b1;
            end
            if (state_q == S_WR_RESP && axi.bready) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
            end
            if (wr_commit) bresp_q <= wr_ok ? 2'b00 : 2'b10;
            if (ar_hs) begin
                ar_addr_q  <= axi.araddr;
                ar_size_q  <= axi.arsize;
                ar_len_q   <= axi.arlen;
                ar_burst_q <= axi.arburst;
            end
            // Loading beat 0 and every accepted non-last beat share one path, so bursts stream back to back.
            if (rd_load0 || rd_adv) begin
                ar_addr_q <= ld_addr;
                beat_q    <= ld_beat;
                rdata_q   <= ld_err ? 32'd0 : mem_q[word_idx(ld_addr)];
                rresp_q   <= ld_err ? 2'b10 : 2'b00;
                rlast_q   <= (ld_beat == ar_len_q);
            end
        end
    end

    // Contents survive reset; a write aborted by reset never reaches the commit state.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_q[i]) mem_q[word_idx(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25040129_axi_sram.sv
// Bench for the AXI SRAM responder: directed scenarios then random traffic, checked by a
// negedge monitor against expected-response queues filled from a byte-level memory model.
module tb_ysyx_25040129_axi_sram;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 4096;
    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state_dbg;

    ysyx_25040129_axi_sram_if bus();

    ysyx_25040129_axi_sram #(
        .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst), .axi(bus.slave), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [34:0] exp_r_q[$];
    logic [1:0]  exp_b_q[$];
    logic [31:0] model_mem [DEPTH];
    int          rmode = 0;
    int          bmode = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_in_range(input logic [31:0] a);
        longint v, b;
        v = {32'b0, a};
        b = {32'b0, BASE};
        return (v >= b) && (v < b + DEPTH * 4);
    endfunction

    function automatic int m_index(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_in_range(a)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model_mem[m_index(a)][8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    function automatic void push_read_exp(input logic [31:0] addr, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst);
        longint sz, blk, a_l, base_w;
        logic [31:0] a, d;
        bit bad, err;
        sz     = longint'(1) << size;
        blk    = (longint'(len) + 1) * sz;
        a_l    = {32'b0, addr};
        base_w = (a_l / blk) * blk;
        bad    = (burst == 2'b11) || (size > 3'd2);
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = addr;
                2'b10:   a = 32'(base_w + ((a_l - base_w + i * sz) % blk));
                default: a = 32'(a_l + i * sz);
            endcase
            err = bad || !m_in_range(a);
            d   = err ? 32'd0 : model_mem[m_index(a)];
            exp_r_q.push_back({(i == int'(len)), (err ? 2'b10 : 2'b00), d});
        end
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input bit chk_lat, input bit chk_ar_block);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs, ar_seen = 0;
        int c = 0, k = 0;
        exp_b_q.push_back(m_in_range(addr) ? 2'b00 : 2'b10);
        model_write(addr, data, strb);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && c < 100) begin
            if (!aw_done && c >= aw_dly) bus.awvalid = 1'b1;
            if (!w_done && c >= w_dly)   bus.wvalid  = 1'b1;
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            if (chk_ar_block && bus.arready) ar_seen = 1;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid  = 1'b0; end
            c++;
        end
        chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            exp_b_q.delete();
            return;
        end
        while (!bus.bvalid && k < 100) begin
            if (chk_ar_block && bus.arready) ar_seen = 1;
            @(posedge clk); #1;
            k++;
        end
        if (chk_lat) chk("wr_latency", k, WR_LAT);
        c = 0;
        while (exp_b_q.size() != 0 && c < 200) begin
            if (chk_ar_block && bus.arready) ar_seen = 1;
            @(posedge clk); #1;
            c++;
        end
        chk("b_done", exp_b_q.size() == 0, 1);
        exp_b_q.delete();
        if (chk_ar_block) chk("ar_blocked_during_write", ar_seen, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [1:0] burst, input bit chk_lat);
        bit hs = 0;
        int c = 0, k = 0;
        push_read_exp(addr, size, len, burst);
        bus.araddr  = addr;
        bus.arsize  = size;
        bus.arlen   = len;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        while (!hs && c < 100) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            c++;
        end
        bus.arvalid = 1'b0;
        chk("ar_accepted", hs, 1);
        if (!hs) begin
            exp_r_q.delete();
            return;
        end
        while (!bus.rvalid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (chk_lat) chk("rd_latency", k, RD_LAT);
        c = 0;
        while (exp_r_q.size() != 0 && c < 500) begin
            @(posedge clk); #1;
            c++;
        end
        chk("r_drained", exp_r_q.size() == 0, 1);
        exp_r_q.delete();
    endtask

    // Ready drivers: 0 = held high, 1 = toggling, 2 = random.
    initial begin
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1:       bus.rready = !bus.rready;
                2:       bus.rready = 1'($urandom_range(0, 1));
                default: bus.rready = 1'b1;
            endcase
            case (bmode)
                2:       bus.bready = 1'($urandom_range(0, 1));
                default: bus.bready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expected responses on every handshake and checks stall stability.
    initial begin
        logic        r_stall = 0, b_stall = 0;
        logic [34:0] r_prev = '0;
        logic [1:0]  b_prev = '0;
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                r_stall = 0;
                b_stall = 0;
            end else begin
                if (r_stall) chk("r_hold", {bus.rvalid, bus.rlast, bus.rresp, bus.rdata}, {1'b1, r_prev});
                if (b_stall) chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, b_prev});
                if (bus.rvalid && bus.rready) begin
                    if (exp_r_q.size() == 0) chk("r_unexpected", bus.rvalid, 0);
                    else begin
                        e = exp_r_q.pop_front();
                        chk("r_beat", {bus.rlast, bus.rresp, bus.rdata}, e);
                    end
                end
                if (bus.bvalid && bus.bready) begin
                    if (exp_b_q.size() == 0) chk("b_unexpected", bus.bvalid, 0);
                    else chk("b_resp", bus.bresp, exp_b_q.pop_front());
                end
                r_stall = bus.rvalid && !bus.rready;
                r_prev  = {bus.rlast, bus.rresp, bus.rdata};
                b_stall = bus.bvalid && !bus.bready;
                b_prev  = bus.bresp;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  sz;
        logic [7:0]  ln;
        logic [1:0]  bu;
        bus.araddr = '0; bus.arvalid = 0; bus.arsize = '0; bus.arlen = '0; bus.arburst = '0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {bus.arready, bus.awready, bus.wready}, 3'b000);
        chk("rst_valid", {bus.rvalid, bus.bvalid, bus.rlast}, 3'b000);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_resp", {bus.rresp, bus.bresp}, 4'b0000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {bus.arready, bus.awready, bus.wready}, 3'b111);

        for (int i = 0; i < 64; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, 0);
        do_write(BASE + 32'(4 * (DEPTH - 2)), $urandom, 4'hF, 0, 0, 0, 0);
        do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 0, 0, 0, 0);

        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0);
        do_read(BASE + 32'h10, 3'd2, 8'd0, 2'b01, 1);
        do_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0, 0);
        do_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1, 0, 1, 0);
        do_read(BASE + 32'h20, 3'd2, 8'd0, 2'b01, 1);

        rmode = 1;
        do_read(BASE, 3'd2, 8'd3, 2'b01, 0);
        rmode = 0;
        do_read(BASE + 32'h08, 3'd2, 8'd3, 2'b10, 0);
        do_read(BASE + 32'h14, 3'd2, 8'd3, 2'b00, 0);
        do_read(BASE + 32'h31, 3'd0, 8'd5, 2'b01, 0);
        do_read(BASE + 32'h46, 3'd1, 8'd3, 2'b10, 0);
        do_read(BASE + 32'h04, 3'd2, 8'd2, 2'b11, 0);
        do_read(BASE + 32'h04, 3'd3, 8'd1, 2'b01, 0);

        do_read(32'h7FFF_FFFC, 3'd2, 8'd2, 2'b01, 0);
        do_read(BASE + 32'(4 * DEPTH - 8), 3'd2, 8'd3, 2'b01, 0);
        do_write(BASE + 32'h4000, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
        do_write(32'h7FFF_FFFC, 32'h8765_4321, 4'hF, 0, 0, 0, 0);
        do_read(BASE, 3'd2, 8'd1, 2'b01, 0);

        // Read parked on AR while a slow-W write runs; it must wait for the B handshake.
        bus.araddr = BASE + 32'h50; bus.arsize = 3'd2; bus.arlen = 8'd0; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        do_write(BASE + 32'h50, 32'hCAFE_F00D, 4'hF, 0, 3, 1, 1);
        do_read(BASE + 32'h50, 3'd2, 8'd0, 2'b01, 1);

        // Reset during WR_WAIT: no response, word untouched.
        bus.awaddr = BASE + 32'h60; bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("abort_hs", {bus.awready, bus.wready}, 2'b11);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_rst_out", {bus.bvalid, bus.awready, bus.arready}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (WR_LAT + 3) @(posedge clk);
        #1;
        do_read(BASE + 32'h60, 3'd2, 8'd0, 2'b01, 1);

        rmode = 2;
        bmode = 2;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = BASE + 32'(4 * $urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) a = a + 32'(4 * DEPTH);
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
            end else begin
                bu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if (bu == 2'b10) ln = 8'((2 << $urandom_range(0, 2)) - 1);
                else             ln = 8'($urandom_range(0, 7));
                a = BASE + 32'(4 * $urandom_range(0, 40));
                if (sz < 3'd2) a = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
                do_read(a, sz, ln, bu, 0);
            end
        end
        rmode = 0;
        bmode = 0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
